// File: rtl/aes_128_key_feeder_if.sv
// Key-feeder bus bundle: host round-key write port plus the core-side
// key handshake (block start, key advance, block done, current key).
//   master : host/core side, drives strobes and write data
//   slave  : feeder side, returns write status and the current round key
interface aes_128_key_feeder_if #(
  parameter int KW = 128,
  parameter int AW = 4
);
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [KW-1:0] wr_data;
  logic          wr_ack;
  logic          wr_err;
  logic          core_start;
  logic          key_ready;
  logic          core_done;
  logic [KW-1:0] key_round;

  modport master (
    output wr_en, wr_addr, wr_data, core_start, key_ready, core_done,
    input  wr_ack, wr_err, key_round
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, core_start, key_ready, core_done,
    output wr_ack, wr_err, key_round
  );
endinterface

// File: rtl/aes_128_key_feeder.sv
// AES-128 round-key store and sequencer. The host loads NR+1 pre-expanded
// round keys; during a block the feeder presents rk[round_idx] to the core
// and advances on each key_ready until core_done.
// Ports:
//   clk        : clock, rising edge
//   kill       : synchronous active-high reset
//   bus        : write port and core key handshake (slave modport)
//   keys_valid : every entry written since the last kill
//   busy       : block in flight
//   round_idx  : current key pointer
//   start_err  : pulse, start seen without a full key set
//   ovr_err    : pulse, key_ready seen at the last round key
//
// state | meaning
// IDLE  | no block in flight; host writes accepted
// RUN   | block in flight; key pointer advances on key_ready
module aes_128_key_feeder #(
  parameter int NR = 10,
  parameter int KW = 128,
  parameter int AW = 4
) (
  input  logic                  clk,
  input  logic                  kill,
  aes_128_key_feeder_if.slave   bus,
  output logic                  keys_valid,
  output logic                  busy,
  output logic [AW-1:0]         round_idx,
  output logic                  start_err,
  output logic                  ovr_err
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state_q, state_d;
  logic [KW-1:0] rk_q [0:NR];
  logic [NR:0]   mask_q, mask_d;
  logic [AW-1:0] idx_q, idx_d;
  logic          wr_ack_q, wr_err_q, start_err_q, ovr_err_q;
  logic          start_err_d, ovr_err_d;
  logic          wr_acc, wr_rej;

  assign busy       = (state_q == RUN);
  assign keys_valid = &mask_q;
  assign round_idx  = idx_q;
  assign start_err  = start_err_q;
  assign ovr_err    = ovr_err_q;
  assign bus.wr_ack = wr_ack_q;
  assign bus.wr_err = wr_err_q;
  assign bus.key_round = keys_valid ? rk_q[idx_q] : '0;

  assign wr_acc = bus.wr_en && !busy && (bus.wr_addr <= AW'(NR));
  assign wr_rej = bus.wr_en && !wr_acc;

  always_comb begin
    mask_d      = mask_q;
    state_d     = state_q;
    idx_d       = idx_q;
    start_err_d = 1'b0;
    ovr_err_d   = 1'b0;

    for (int i = 0; i <= NR; i++) begin
      if (wr_acc && (bus.wr_addr == AW'(i))) mask_d[i] = 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        // Start judges the mask including a same-cycle write.
        if (bus.core_start) begin
          if (&mask_d) state_d = RUN;
          else         start_err_d = 1'b1;
        end
      end
      RUN: begin
        // Done takes priority over a coincident key_ready.
        if (bus.core_done) begin
          idx_d = '0;
          if (!bus.core_start) state_d = IDLE;
        end else if (bus.key_ready) begin
          if (idx_q == AW'(NR)) ovr_err_d = 1'b1;
          else                  idx_d = idx_q + AW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (kill) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      mask_q      <= '0;
      wr_ack_q    <= 1'b0;
      wr_err_q    <= 1'b0;
      start_err_q <= 1'b0;
      ovr_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      mask_q      <= mask_d;
      wr_ack_q    <= wr_acc;
      wr_err_q    <= wr_rej;
      start_err_q <= start_err_d;
      ovr_err_q   <= ovr_err_d;
    end
  end

  // Key storage survives kill; only the written-mask is cleared.
  always_ff @(posedge clk) begin
    if (!kill && wr_acc) rk_q[bus.wr_addr] <= bus.wr_data;
  end

endmodule

// File: tb/tb_aes_128_key_feeder.sv
module tb_aes_128_key_feeder;
  localparam int NR = 10;
  localparam int KW = 128;
  localparam int AW = 4;

  localparam logic [3:0] EV_ACK  = 4'b1000;
  localparam logic [3:0] EV_WERR = 4'b0100;
  localparam logic [3:0] EV_SERR = 4'b0010;
  localparam logic [3:0] EV_OVR  = 4'b0001;

  logic          clk = 1'b0;
  logic          kill;
  logic          keys_valid, busy, start_err, ovr_err;
  logic [AW-1:0] round_idx;

  int total = 0;
  int bad   = 0;
  logic [3:0]    exp_q [$];
  logic [KW-1:0] rk_model [0:NR];

  aes_128_key_feeder_if #(.KW(KW), .AW(AW)) bus ();

  aes_128_key_feeder #(.NR(NR), .KW(KW), .AW(AW)) dut (
    .clk(clk), .kill(kill), .bus(bus),
    .keys_valid(keys_valid), .busy(busy), .round_idx(round_idx),
    .start_err(start_err), .ovr_err(ovr_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [KW-1:0] obs, input logic [KW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse scoreboard: every pulse must match the oldest expected event.
  always @(negedge clk) begin
    logic [3:0] ev;
    ev = {bus.wr_ack, bus.wr_err, start_err, ovr_err};
    if (ev != 4'b0000) begin
      if (exp_q.size() == 0) check("unexpected_pulse", KW'(ev), KW'(0));
      else check("pulse_event", KW'(ev), KW'(exp_q.pop_front()));
    end
  end

  task automatic write_key(input int addr, input logic [KW-1:0] data, input logic [3:0] ev);
    bus.wr_en = 1'b1; bus.wr_addr = AW'(addr); bus.wr_data = data;
    exp_q.push_back(ev);
    tick();
    bus.wr_en = 1'b0;
  endtask

  task automatic pulse_ready();
    bus.key_ready = 1'b1;
    tick();
    bus.key_ready = 1'b0;
  endtask

  initial begin
    for (int i = 0; i <= NR; i++) rk_model[i] = {16'h1111, 112'd0} + KW'(i);
    kill = 1'b1;
    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.core_start = 1'b0; bus.key_ready = 1'b0; bus.core_done = 1'b0;
    tick(); tick();
    kill = 1'b0;

    // 1: reset state, full key load
    check("rst_keys_valid", KW'(keys_valid), KW'(0));
    check("rst_busy", KW'(busy), KW'(0));
    check("rst_idx", KW'(round_idx), KW'(0));
    check("rst_key_round", bus.key_round, '0);
    for (int i = 0; i <= NR; i++) begin
      write_key(i, rk_model[i], EV_ACK);
      check("load_keys_valid", KW'(keys_valid), KW'(i == NR));
    end
    tick();
    check("load_key_round", bus.key_round, rk_model[0]);

    // 2: walk a full block
    bus.core_start = 1'b1; tick(); bus.core_start = 1'b0;
    check("run_busy", KW'(busy), KW'(1));
    check("run_idx0", KW'(round_idx), KW'(0));
    check("run_key0", bus.key_round, rk_model[0]);
    for (int k = 1; k <= NR; k++) begin
      pulse_ready();
      check("run_idx", KW'(round_idx), KW'(k));
      check("run_key", bus.key_round, rk_model[k]);
      tick(); tick();
    end

    // 4: rejected write while busy, overrun at last key
    write_key(3, {KW{1'b1}}, EV_WERR);
    exp_q.push_back(EV_OVR);
    pulse_ready();
    check("ovr_idx_hold", KW'(round_idx), KW'(NR));
    bus.core_done = 1'b1; tick(); bus.core_done = 1'b0;
    check("done_busy", KW'(busy), KW'(0));
    check("done_idx", KW'(round_idx), KW'(0));
    write_key(12, {KW{1'b1}}, EV_WERR);
    check("bad_addr_keys_valid", KW'(keys_valid), KW'(1));
    tick();

    // 5: back-to-back block, then done+ready at last key
    bus.core_start = 1'b1; tick(); bus.core_start = 1'b0;
    pulse_ready(); pulse_ready();
    bus.core_done = 1'b1; bus.core_start = 1'b1; tick();
    bus.core_done = 1'b0; bus.core_start = 1'b0;
    check("b2b_busy", KW'(busy), KW'(1));
    check("b2b_idx", KW'(round_idx), KW'(0));
    for (int k = 1; k <= 3; k++) pulse_ready();
    check("rk3_unchanged", bus.key_round, rk_model[3]);
    for (int k = 4; k <= NR; k++) pulse_ready();
    check("b2b_idx_last", KW'(round_idx), KW'(NR));
    bus.key_ready = 1'b1; bus.core_done = 1'b1; tick();
    bus.key_ready = 1'b0; bus.core_done = 1'b0;
    check("done_wins_idx", KW'(round_idx), KW'(0));
    check("done_wins_busy", KW'(busy), KW'(0));
    check("done_wins_ovr", KW'(ovr_err), KW'(0));
    tick();

    // 6: kill mid-block
    bus.core_start = 1'b1; tick(); bus.core_start = 1'b0;
    for (int k = 1; k <= 5; k++) pulse_ready();
    check("pre_kill_idx", KW'(round_idx), KW'(5));
    kill = 1'b1; bus.key_ready = 1'b1; tick();
    kill = 1'b0; bus.key_ready = 1'b0;
    check("kill_idx", KW'(round_idx), KW'(0));
    check("kill_busy", KW'(busy), KW'(0));
    check("kill_keys_valid", KW'(keys_valid), KW'(0));
    check("kill_key_round", bus.key_round, '0);
    exp_q.push_back(EV_SERR);
    bus.core_start = 1'b1; tick(); bus.core_start = 1'b0;
    check("kill_start_busy", KW'(busy), KW'(0));

    // 3: ten keys only, then the 11th together with start
    for (int i = 0; i < NR; i++) write_key(i, rk_model[i], EV_ACK);
    exp_q.push_back(EV_SERR);
    bus.core_start = 1'b1; tick(); bus.core_start = 1'b0;
    check("partial_busy", KW'(busy), KW'(0));
    check("partial_key_round", bus.key_round, '0);
    bus.core_start = 1'b1;
    write_key(NR, rk_model[NR], EV_ACK);
    bus.core_start = 1'b0;
    check("wr_start_busy", KW'(busy), KW'(1));
    check("wr_start_key", bus.key_round, rk_model[0]);
    bus.core_done = 1'b1; tick(); bus.core_done = 1'b0;
    tick(); tick();
    check("scoreboard_drained", KW'(exp_q.size()), KW'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
